// File: rtl/bcd_updown_ndigit_pkg.sv
// bcd_updown_ndigit_pkg
// Shared constants, types and helpers for the N-digit BCD up/down counter.
// There are no ports. The package provides:
//   DIGIT_W      bits per BCD digit
//   BCD_MAX      largest legal digit value (9)
//   BCD_MIN      smallest legal digit value (0)
//   bcd_digit_t  one BCD digit
//   clamp_digit  maps any 4-bit value onto a legal BCD digit
//   step_digit   gives the next digit value in a count direction
package bcd_updown_ndigit_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Codes above 9 (A..F) are not BCD. A load saturates them to 9 so that an
  // illegal code never reaches a stored digit.
  function automatic bcd_digit_t clamp_digit(input bcd_digit_t value);
    return (value > BCD_MAX) ? BCD_MAX : value;
  endfunction

  // One BCD step with digit-level wrap: 9 -> 0 going up, 0 -> 9 going down.
  // Out-of-range inputs are folded onto the matching wrap value. The stored
  // digit can never actually hold such a value.
  function automatic bcd_digit_t step_digit(input bcd_digit_t value, input logic up);
    bcd_digit_t next;
    if (up) begin
      next = (value >= BCD_MAX) ? BCD_MIN : value + 4'd1;
    end else begin
      next = (value == BCD_MIN || value > BCD_MAX) ? BCD_MAX : value - 4'd1;
    end
    return next;
  endfunction

endpackage

// File: rtl/bcd_updown_ndigit_digit_cell.sv
// bcd_digit_cell
// A single BCD digit of the cascaded up/down counter.
// Ports:
//   clk100Mhz   system clock, rising edge
//   CLR         asynchronous active-low reset; clears the digit to 0
//   load_value  parallel load value for this digit (clamped to 9)
//   load        synchronous load; takes priority over stepping
//   step        counter-wide step enable for this cycle
//   up          direction: 1 = increment, 0 = decrement
//   carry_in    carry (up) or borrow (down) from the next lower digit
//   digit       current digit value, registered
//   carry_out   carry/borrow to the next higher digit (combinational)
module bcd_digit_cell
  import bcd_updown_ndigit_pkg::*;
(
  input  logic       clk100Mhz,
  input  logic       CLR,
  input  bcd_digit_t load_value,
  input  logic       load,
  input  logic       step,
  input  logic       up,
  input  logic       carry_in,
  output bcd_digit_t digit,
  output logic       carry_out
);

  bcd_digit_t digit_next;

  assign digit_next = step_digit(digit, up);

  // This digit only moves when the whole counter steps and every lower digit
  // is sitting at its terminal value for the current direction.
  always_ff @(posedge clk100Mhz or negedge CLR) begin
    if (!CLR) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= clamp_digit(load_value);
    end else if (step && carry_in) begin
      digit <= digit_next;
    end
  end

  // The chain is combinational from the digit values and up. It is not
  // gated by step, so its final output doubles as the terminal-count detector.
  assign carry_out = carry_in & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

endmodule

// File: rtl/bcd_updown_ndigit.sv
// bcd_updown_ndigit
// N-digit cascaded BCD up/down counter with a free-running prescaler,
// parallel load with per-digit clamping, and either saturating or wrapping
// behaviour at the terminal count.
// Parameters:
//   NDIGITS    number of BCD digits (1..8)
//   DIV_WIDTH  prescaler width; one tick every 2^DIV_WIDTH clocks (1..32)
//   WRAP       0 = hold at the terminal value, 1 = wrap 0 <-> all 9s
// Ports:
//   clk100Mhz  system clock, rising edge
//   CLR        asynchronous active-low reset
//   D          parallel load value; digit k is D[4k+3:4k]
//   ENABLE     count enable, only sampled on tick cycles
//   LOAD       synchronous load request; wins over counting
//   UP         direction: 1 = increment, 0 = decrement
//   Q          current BCD count, registered
//   TICK       one-cycle pulse when the prescaler is all ones
//   AT_LIMIT   Q is all 9s going up, or all 0s going down
//   CO         one-cycle pulse after a counting tick taken at the limit
module bcd_updown_ndigit
  import bcd_updown_ndigit_pkg::*;
#(
  parameter int NDIGITS   = 2,
  parameter int DIV_WIDTH = 27,
  parameter int WRAP      = 0
) (
  input  logic                       clk100Mhz,
  input  logic                       CLR,
  input  logic [DIGIT_W*NDIGITS-1:0] D,
  input  logic                       ENABLE,
  input  logic                       LOAD,
  input  logic                       UP,
  output logic [DIGIT_W*NDIGITS-1:0] Q,
  output logic                       TICK,
  output logic                       AT_LIMIT,
  output logic                       CO
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic [DIV_WIDTH-1:0] prescaler;
  logic [NDIGITS:0]     carry;
  logic                 count_tick;
  logic                 step;

  // The prescaler is a plain free-running counter. Counting uses it as a
  // qualifier so that everything stays in the single clk100Mhz domain.
  always_ff @(posedge clk100Mhz or negedge CLR) begin
    if (!CLR) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + DIV_WIDTH'(1);
    end
  end

  // The prescaler is already cleared while CLR is low. CLR also gates TICK
  // directly, so the pulse cannot be seen while reset is asserted.
  assign TICK = CLR & (&prescaler);

  // With carry[0] tied high, the top of the chain is 1 exactly when every
  // digit sits at 9 (up) or at 0 (down). That is the limit condition.
  assign carry[0] = 1'b1;
  assign AT_LIMIT = carry[NDIGITS];

  assign count_tick = TICK & ENABLE & ~LOAD;

  // In saturate mode the step is suppressed at the limit so that Q holds.
  // In wrap mode the normal digit rollover already produces 0 or all 9s.
  assign step = count_tick & (WRAP_EN | ~AT_LIMIT);

  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    bcd_digit_cell u_digit (
      .clk100Mhz  (clk100Mhz),
      .CLR        (CLR),
      .load_value (D[DIGIT_W*k +: DIGIT_W]),
      .load       (LOAD),
      .step       (step),
      .up         (UP),
      .carry_in   (carry[k]),
      .digit      (Q[DIGIT_W*k +: DIGIT_W]),
      .carry_out  (carry[k+1])
    );
  end

  // CO marks a counting tick taken while at the limit. A load in the same
  // cycle cancels the count, so LOAD keeps CO low as well.
  always_ff @(posedge clk100Mhz or negedge CLR) begin
    if (!CLR) begin
      CO <= 1'b0;
    end else begin
      CO <= count_tick & AT_LIMIT;
    end
  end

endmodule
